// File: rtl/rat_multi.sv
// Multi-slot register alias table: renames RENAME_W instructions per cycle.
// Latency: source reads are combinational in the same cycle; table updates land on the next clk edge.
// Backpressure: none. Every valid slot is accepted each cycle.
// Optional build macro RAT_WB_BYPASS_EN forwards a same-cycle writeback to readers.
module rat_multi #(
  parameter int XLEN     = 32,
  parameter int AREG_W   = 5,
  parameter int TAG_W    = 7,
  parameter int RENAME_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RENAME_W-1:0]        rename_valid,
  input  logic [RENAME_W-1:0]        rename_rd_en,
  input  logic [RENAME_W*AREG_W-1:0] rename_rd,
  input  logic [RENAME_W*TAG_W-1:0]  rename_robid,
  input  logic [RENAME_W*AREG_W-1:0] rename_rs1,
  input  logic [RENAME_W*AREG_W-1:0] rename_rs2,
  output logic [RENAME_W-1:0]        rat_rs1_valid,
  output logic [RENAME_W-1:0]        rat_rs2_valid,
  output logic [RENAME_W*XLEN-1:0]   rat_rs1_tagval,
  output logic [RENAME_W*XLEN-1:0]   rat_rs2_tagval,
  input  logic                       wb_valid,
  input  logic                       wb_error,
  input  logic [TAG_W-1:0]           wb_robid,
  input  logic [AREG_W-1:0]          wb_rd,
  input  logic [XLEN-1:0]            wb_result,
  input  logic                       rob_flush,
  input  logic                       rob_ret_valid,
  input  logic [AREG_W-1:0]          rob_ret_rd,
  input  logic [TAG_W-1:0]           rob_ret_robid,
  input  logic [XLEN-1:0]            rob_ret_result
);

  localparam int NREG = 1 << AREG_W;

  // ARCH: committed value is current; PEND: waiting on tag; SPEC: speculative value held.
  typedef enum logic [1:0] {
    ST_ARCH = 2'd0,
    ST_PEND = 2'd1,
    ST_SPEC = 2'd2
  } ent_state_e;

  ent_state_e       st_q   [NREG];
  ent_state_e       st_d   [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [XLEN-1:0]  spec_q [NREG];
  logic [XLEN-1:0]  spec_d [NREG];
  logic [XLEN-1:0]  comm_q [NREG];
  logic [XLEN-1:0]  comm_d [NREG];

  // Resolve every slot's two sources: x0, older in-bundle producer, wb bypass, then table.
  always_comb begin
    logic [AREG_W-1:0] src;
    logic              hit;
    logic [TAG_W-1:0]  hit_tag;
    logic              vld;
    logic [XLEN-1:0]   dat;
    rat_rs1_valid  = '0;
    rat_rs2_valid  = '0;
    rat_rs1_tagval = '0;
    rat_rs2_tagval = '0;
    src     = '0;
    hit     = 1'b0;
    hit_tag = '0;
    vld     = 1'b1;
    dat     = '0;
    for (int i = 0; i < RENAME_W; i++) begin
      for (int k = 0; k < 2; k++) begin
        src = (k == 0) ? rename_rs1[i*AREG_W +: AREG_W] : rename_rs2[i*AREG_W +: AREG_W];
        // Ascending scan so the youngest older writer of src ends up in hit_tag.
        hit     = 1'b0;
        hit_tag = '0;
        for (int j = 0; j < i; j++) begin
          if (rename_valid[j] && rename_rd_en[j] && rename_rd[j*AREG_W +: AREG_W] == src) begin
            hit     = 1'b1;
            hit_tag = rename_robid[j*TAG_W +: TAG_W];
          end
        end
        vld = 1'b1;
        dat = '0;
        if (rst) begin
          vld = 1'b1;
          dat = comm_q[src];
        end else if (src == '0) begin
          vld = 1'b1;
          dat = '0;
        end else if (hit) begin
          vld = 1'b0;
          dat = XLEN'(hit_tag);
`ifdef RAT_WB_BYPASS_EN
        end else if (st_q[src] == ST_PEND && wb_valid && !wb_error && wb_robid == tag_q[src]) begin
          vld = 1'b1;
          dat = wb_result;
`endif
        end else begin
          case (st_q[src])
            ST_PEND: begin
              vld = 1'b0;
              dat = XLEN'(tag_q[src]);
            end
            ST_SPEC: dat = spec_q[src];
            default: dat = comm_q[src];
          endcase
        end
        if (k == 0) begin
          rat_rs1_valid[i]              = vld;
          rat_rs1_tagval[i*XLEN +: XLEN] = dat;
        end else begin
          rat_rs2_valid[i]              = vld;
          rat_rs2_tagval[i*XLEN +: XLEN] = dat;
        end
      end
    end
  end

  // Next table state: writeback, then retire, then rename, then flush; later steps override.
  always_comb begin
    logic [AREG_W-1:0] rd;
    st_d   = st_q;
    tag_d  = tag_q;
    spec_d = spec_q;
    comm_d = comm_q;
    rd     = '0;
    if (wb_valid && !wb_error && wb_rd != '0 &&
        st_q[wb_rd] == ST_PEND && tag_q[wb_rd] == wb_robid) begin
      st_d[wb_rd]   = ST_SPEC;
      spec_d[wb_rd] = wb_result;
    end
    if (rob_ret_valid && rob_ret_rd != '0) begin
      comm_d[rob_ret_rd] = rob_ret_result;
      if (st_d[rob_ret_rd] != ST_PEND && tag_d[rob_ret_rd] == rob_ret_robid) begin
        st_d[rob_ret_rd] = ST_ARCH;
      end
    end
    for (int i = 0; i < RENAME_W; i++) begin
      rd = rename_rd[i*AREG_W +: AREG_W];
      if (rename_valid[i] && rename_rd_en[i] && rd != '0) begin
        st_d[rd]  = ST_PEND;
        tag_d[rd] = rename_robid[i*TAG_W +: TAG_W];
      end
    end
    // Flush keeps only the committed-file write; speculative tag/value updates are dropped.
    if (rob_flush) begin
      tag_d  = tag_q;
      spec_d = spec_q;
      for (int r = 0; r < NREG; r++) begin
        st_d[r] = ST_ARCH;
      end
    end
  end

  // Table registers with synchronous reset to an all-committed, all-zero file.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        st_q[r]   <= ST_ARCH;
        tag_q[r]  <= '0;
        spec_q[r] <= '0;
        comm_q[r] <= '0;
      end
    end else begin
      st_q   <= st_d;
      tag_q  <= tag_d;
      spec_q <= spec_d;
      comm_q <= comm_d;
    end
  end

endmodule

// File: tb/tb_rat_multi.sv
// Self-checking bench for rat_multi: directed scenarios then randomized traffic.
// Expected reads come from a per-register model updated once per clock.
// No backpressure to model; all waits are fixed clock counts.
module tb_rat_multi;

  localparam int XLEN     = 32;
  localparam int AREG_W   = 5;
  localparam int TAG_W    = 7;
  localparam int RENAME_W = 2;
  localparam int NREG     = 1 << AREG_W;

  logic                       clk;
  logic                       rst;
  logic [RENAME_W-1:0]        rename_valid;
  logic [RENAME_W-1:0]        rename_rd_en;
  logic [RENAME_W*AREG_W-1:0] rename_rd;
  logic [RENAME_W*TAG_W-1:0]  rename_robid;
  logic [RENAME_W*AREG_W-1:0] rename_rs1;
  logic [RENAME_W*AREG_W-1:0] rename_rs2;
  logic [RENAME_W-1:0]        rat_rs1_valid;
  logic [RENAME_W-1:0]        rat_rs2_valid;
  logic [RENAME_W*XLEN-1:0]   rat_rs1_tagval;
  logic [RENAME_W*XLEN-1:0]   rat_rs2_tagval;
  logic                       wb_valid;
  logic                       wb_error;
  logic [TAG_W-1:0]           wb_robid;
  logic [AREG_W-1:0]          wb_rd;
  logic [XLEN-1:0]            wb_result;
  logic                       rob_flush;
  logic                       rob_ret_valid;
  logic [AREG_W-1:0]          rob_ret_rd;
  logic [TAG_W-1:0]           rob_ret_robid;
  logic [XLEN-1:0]            rob_ret_result;

  int checks = 0;
  int errors = 0;

  // Reference model: per register, waiting-on-producer flag, has-speculative-value flag.
  bit               m_pend    [NREG];
  bit               m_hasspec [NREG];
  logic [TAG_W-1:0] m_tag     [NREG];
  logic [XLEN-1:0]  m_spec    [NREG];
  logic [XLEN-1:0]  m_comm    [NREG];

  rat_multi #(.XLEN(XLEN), .AREG_W(AREG_W), .TAG_W(TAG_W), .RENAME_W(RENAME_W)) dut (
    .clk(clk), .rst(rst),
    .rename_valid(rename_valid), .rename_rd_en(rename_rd_en), .rename_rd(rename_rd),
    .rename_robid(rename_robid), .rename_rs1(rename_rs1), .rename_rs2(rename_rs2),
    .rat_rs1_valid(rat_rs1_valid), .rat_rs2_valid(rat_rs2_valid),
    .rat_rs1_tagval(rat_rs1_tagval), .rat_rs2_tagval(rat_rs2_tagval),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid), .wb_rd(wb_rd),
    .wb_result(wb_result), .rob_flush(rob_flush), .rob_ret_valid(rob_ret_valid),
    .rob_ret_rd(rob_ret_rd), .rob_ret_robid(rob_ret_robid), .rob_ret_result(rob_ret_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // What a reader in slot i asking for register s should see right now.
  function automatic void model_read(input int i, input logic [AREG_W-1:0] s,
                                     output logic v, output logic [XLEN-1:0] d);
    if (rst) begin v = 1'b1; d = m_comm[s]; return; end
    if (s == 0) begin v = 1'b1; d = '0; return; end
    for (int j = i - 1; j >= 0; j--) begin
      if (rename_valid[j] && rename_rd_en[j] && rename_rd[j*AREG_W +: AREG_W] == s) begin
        v = 1'b0; d = XLEN'(rename_robid[j*TAG_W +: TAG_W]); return;
      end
    end
`ifdef RAT_WB_BYPASS_EN
    if (m_pend[s] && wb_valid && !wb_error && wb_robid == m_tag[s]) begin
      v = 1'b1; d = wb_result; return;
    end
`endif
    if (m_pend[s]) begin v = 1'b0; d = XLEN'(m_tag[s]); end
    else if (m_hasspec[s]) begin v = 1'b1; d = m_spec[s]; end
    else begin v = 1'b1; d = m_comm[s]; end
  endfunction

  // Apply one clock edge worth of effects using the inputs held across that edge.
  task automatic model_update();
    logic [AREG_W-1:0] rd;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_pend[r] = 0; m_hasspec[r] = 0; m_tag[r] = '0; m_spec[r] = '0; m_comm[r] = '0;
      end
      return;
    end
    if (rob_ret_valid && rob_ret_rd != 0) m_comm[rob_ret_rd] = rob_ret_result;
    if (rob_flush) begin
      for (int r = 0; r < NREG; r++) begin m_pend[r] = 0; m_hasspec[r] = 0; end
      return;
    end
    if (wb_valid && !wb_error && wb_rd != 0 && m_pend[wb_rd] && m_tag[wb_rd] == wb_robid) begin
      m_pend[wb_rd] = 0; m_hasspec[wb_rd] = 1; m_spec[wb_rd] = wb_result;
    end
    if (rob_ret_valid && rob_ret_rd != 0 && !m_pend[rob_ret_rd] && m_tag[rob_ret_rd] == rob_ret_robid)
      m_hasspec[rob_ret_rd] = 0;
    for (int i = 0; i < RENAME_W; i++) begin
      rd = rename_rd[i*AREG_W +: AREG_W];
      if (rename_valid[i] && rename_rd_en[i] && rd != 0) begin
        m_pend[rd] = 1; m_hasspec[rd] = 0; m_tag[rd] = rename_robid[i*TAG_W +: TAG_W];
      end
    end
  endtask

  task automatic check_all();
    logic v;
    logic [XLEN-1:0] d;
    for (int i = 0; i < RENAME_W; i++) begin
      model_read(i, rename_rs1[i*AREG_W +: AREG_W], v, d);
      chk($sformatf("s%0d_rs1_valid", i), XLEN'(rat_rs1_valid[i]), XLEN'(v));
      chk($sformatf("s%0d_rs1_tagval", i), rat_rs1_tagval[i*XLEN +: XLEN], d);
      model_read(i, rename_rs2[i*AREG_W +: AREG_W], v, d);
      chk($sformatf("s%0d_rs2_valid", i), XLEN'(rat_rs2_valid[i]), XLEN'(v));
      chk($sformatf("s%0d_rs2_tagval", i), rat_rs2_tagval[i*XLEN +: XLEN], d);
    end
  endtask

  // Inputs are driven just after negedge; compare, take the edge, advance the model.
  task automatic tick();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    rename_valid = '0; rename_rd_en = '0; rename_rd = '0; rename_robid = '0;
    rename_rs1 = '0; rename_rs2 = '0;
    wb_valid = 0; wb_error = 0; wb_robid = '0; wb_rd = '0; wb_result = '0;
    rob_flush = 0; rob_ret_valid = 0; rob_ret_rd = '0; rob_ret_robid = '0; rob_ret_result = '0;
  endtask

  task automatic ren(input int slot, input int rd, input int tag);
    rename_valid[slot] = 1'b1;
    rename_rd_en[slot] = 1'b1;
    rename_rd[slot*AREG_W +: AREG_W] = AREG_W'(rd);
    rename_robid[slot*TAG_W +: TAG_W] = TAG_W'(tag);
  endtask

  task automatic wb(input int rd, input int tag, input logic [XLEN-1:0] res);
    wb_valid = 1'b1; wb_rd = AREG_W'(rd); wb_robid = TAG_W'(tag); wb_result = res;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) begin
      m_pend[r] = 0; m_hasspec[r] = 0; m_tag[r] = '0; m_spec[r] = '0; m_comm[r] = '0;
    end
    idle();
    rst = 1'b1;
    @(posedge clk); model_update(); @(negedge clk);
    // Reset still asserted: outputs show the committed file.
    rename_rs1 = {AREG_W'(7), AREG_W'(5)};
    tick();
    rst = 1'b0;

    // 1: fresh table reads x5 and x0 as ready zeros.
    idle(); rename_valid[0] = 1; rename_rs1[0 +: AREG_W] = 5;
    #1;
    chk("t1_rs1_valid", XLEN'(rat_rs1_valid[0]), 1);
    chk("t1_rs1_val", rat_rs1_tagval[0 +: XLEN], 0);
    chk("t1_rs2_valid", XLEN'(rat_rs2_valid[0]), 1);
    chk("t1_rs2_val", rat_rs2_tagval[0 +: XLEN], 0);
    tick();

    // 2: in-bundle dependency, then table shows PEND.
    idle(); ren(0, 3, 'h10); rename_valid[1] = 1; rename_rs1[AREG_W +: AREG_W] = 3;
    #1;
    chk("t2_fwd_valid", XLEN'(rat_rs1_valid[1]), 0);
    chk("t2_fwd_tag", rat_rs1_tagval[XLEN +: XLEN], 'h10);
    tick();
    idle(); rename_rs1[0 +: AREG_W] = 3;
    #1;
    chk("t2_pend_valid", XLEN'(rat_rs1_valid[0]), 0);
    chk("t2_pend_tag", rat_rs1_tagval[0 +: XLEN], 'h10);
    tick();

    // 3: stale writeback ignored, then the matching one.
    idle(); wb(3, 'h0F, 32'h1234); rename_rs1[0 +: AREG_W] = 3;
    tick();
    idle(); rename_rs1[0 +: AREG_W] = 3;
    #1;
    chk("t3_stale_tag", rat_rs1_tagval[0 +: XLEN], 'h10);
    tick();
    idle(); wb(3, 'h10, 32'hDEADBEEF); rename_rs1[0 +: AREG_W] = 3;
    #1;
`ifdef RAT_WB_BYPASS_EN
    chk("t3_byp_valid", XLEN'(rat_rs1_valid[0]), 1);
    chk("t3_byp_val", rat_rs1_tagval[0 +: XLEN], 32'hDEADBEEF);
`else
    chk("t3_nobyp_valid", XLEN'(rat_rs1_valid[0]), 0);
    chk("t3_nobyp_tag", rat_rs1_tagval[0 +: XLEN], 'h10);
`endif
    tick();
    idle(); rename_rs1[0 +: AREG_W] = 3;
    #1;
    chk("t3_spec_valid", XLEN'(rat_rs1_valid[0]), 1);
    chk("t3_spec_val", rat_rs1_tagval[0 +: XLEN], 32'hDEADBEEF);
    tick();

    // 4: rename beats a same-cycle writeback; retire of the old tag leaves PEND.
    idle(); ren(0, 3, 'h10); tick();
    idle(); ren(0, 3, 'h11); wb(3, 'h10, 32'h5); tick();
    idle(); rob_ret_valid = 1; rob_ret_rd = 3; rob_ret_robid = 'h10; rob_ret_result = 7;
    rename_rs1[0 +: AREG_W] = 3;
    #1;
    chk("t4_pend_tag", rat_rs1_tagval[0 +: XLEN], 'h11);
    tick();
    idle(); rename_rs1[0 +: AREG_W] = 3;
    #1;
    chk("t4_still_pend", XLEN'(rat_rs1_valid[0]), 0);
    tick();

    // 5: x4 speculative, flush with a same-cycle rename returns the committed value.
    idle(); rob_ret_valid = 1; rob_ret_rd = 4; rob_ret_robid = 'h1F; rob_ret_result = 1; tick();
    idle(); ren(0, 4, 'h20); tick();
    idle(); wb(4, 'h20, 32'h55); tick();
    idle(); rename_rs1[0 +: AREG_W] = 4;
    #1;
    chk("t5_spec_val", rat_rs1_tagval[0 +: XLEN], 'h55);
    tick();
    idle(); rob_flush = 1; ren(0, 4, 'h21); tick();
    idle(); rename_rs1[0 +: AREG_W] = 4; rename_rs2[0 +: AREG_W] = 3;
    #1;
    chk("t5_flush_valid", XLEN'(rat_rs1_valid[0]), 1);
    chk("t5_flush_val", rat_rs1_tagval[0 +: XLEN], 1);
    chk("t5_comm3_val", rat_rs2_tagval[0 +: XLEN], 7);
    tick();

    // 6: x0 is immune to rename and writeback.
    idle(); ren(0, 0, 'h30); wb(0, 'h30, 32'h9); tick();
    idle(); rename_rs1[0 +: AREG_W] = 0;
    #1;
    chk("t6_x0_valid", XLEN'(rat_rs1_valid[0]), 1);
    chk("t6_x0_val", rat_rs1_tagval[0 +: XLEN], 0);
    tick();

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int i = 0; i < RENAME_W; i++) begin
        rename_valid[i] = 1'($urandom_range(0, 1));
        rename_rd_en[i] = 1'($urandom_range(0, 3) != 0);
        rename_rd[i*AREG_W +: AREG_W] = AREG_W'($urandom_range(0, 7));
        rename_robid[i*TAG_W +: TAG_W] = TAG_W'($urandom);
        rename_rs1[i*AREG_W +: AREG_W] = AREG_W'($urandom_range(0, 7));
        rename_rs2[i*AREG_W +: AREG_W] = AREG_W'($urandom_range(0, 7));
      end
      wb_valid = 1'($urandom_range(0, 1));
      wb_error = 1'($urandom_range(0, 9) == 0);
      wb_rd = AREG_W'($urandom_range(0, 7));
      wb_robid = ($urandom_range(0, 3) != 0) ? m_tag[wb_rd] : TAG_W'($urandom);
      wb_result = $urandom;
      rob_ret_valid = 1'($urandom_range(0, 2) == 0);
      rob_ret_rd = AREG_W'($urandom_range(0, 7));
      rob_ret_robid = ($urandom_range(0, 1) != 0) ? m_tag[rob_ret_rd] : TAG_W'($urandom);
      rob_ret_result = $urandom;
      rob_flush = 1'($urandom_range(0, 29) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rat_multi.md
Name: rat_multi

Overview:
- Parametrised, multi-slot register alias table for the rename stage.
- Each cycle, up to RENAME_W instructions are renamed in program order. Slot 0 is the oldest.
- Per slot it supplies each source as either a ready value or a producer ROB tag, and it records the destination's new producer tag.
- It tracks writeback, retirement and ROB flush, and keeps the committed architectural file internally.

Parameters:
- XLEN, 32, data width.
- AREG_W, 5, architectural register index width (2**AREG_W registers).
- TAG_W, 7, ROB tag width.
- RENAME_W, 2, rename slots per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rename_valid  in  RENAME_W  per-slot instruction valid.
- rename_rd_en  in  RENAME_W  per-slot destination write enable.
- rename_rd  in  RENAME_W*AREG_W  destination index; slot i occupies bits [i*AREG_W +: AREG_W].
- rename_robid  in  RENAME_W*TAG_W  ROB tag of the slot.
- rename_rs1, rename_rs2  in  RENAME_W*AREG_W  source indices.
- rat_rs1_valid, rat_rs2_valid  out  RENAME_W  1 = tagval is a value, 0 = tagval is a tag.
- rat_rs1_tagval, rat_rs2_tagval  out  RENAME_W*XLEN  value, or tag zero-extended to XLEN.
- wb_valid  in  1  writeback valid.
- wb_error  in  1  writeback carries an exception.
- wb_robid  in  TAG_W  producing tag.
- wb_rd  in  AREG_W  destination.
- wb_result  in  XLEN  result.
- rob_flush  in  1  squash all speculative state.
- rob_ret_valid  in  1  retire valid.
- rob_ret_rd  in  AREG_W  retiring destination.
- rob_ret_robid  in  TAG_W  retiring tag.
- rob_ret_result  in  XLEN  retiring value.

Behaviour:
- Per-register entry:
  - state ARCH/PEND/SPEC, tag[TAG_W], spec[XLEN].
  - Separate comm[XLEN] array.
- Reset: every entry is ARCH, tag=0, spec=0, comm=0.
  - All outputs are combinational. During reset cycles they reflect the reset state: valid=1, tagval=comm.
- Reads are combinational, same cycle. For slot i and source s, the first matching rule applies:
  1. s==0 → valid=1, value 0.
  2. Some older slot j<i with rename_valid[j]&rename_rd_en[j]&rd[j]==s → valid=0, tag of the youngest such j.
  3. Entry PEND, wb_valid&~wb_error, wb_robid==entry.tag (bypass, see feature) → valid=1, wb_result.
  4. Otherwise by entry state: ARCH → comm[s]; SPEC → spec[s]; PEND → valid=0, entry.tag.
- Updates on posedge clk, applied in this order (later steps win):
  - a) Writeback: wb_valid & ~wb_error & entry[wb_rd].state==PEND & entry.tag==wb_robid → SPEC, spec=wb_result.
    - Tag mismatch (stale producer) is ignored.
    - wb_error leaves the entry PEND.
  - b) Retire: rob_ret_valid → comm[rob_ret_rd]=rob_ret_result.
    - If the entry is not PEND and its tag==rob_ret_robid → ARCH.
  - c) Rename: for each valid slot with rd_en and rd!=0 → PEND, tag=robid.
    - Same rd in several slots: the youngest slot wins.
    - Rename beats a same-cycle writeback or retire to that register.
  - d) rob_flush: every entry → ARCH.
    - The comm write from b) in the same cycle still happens.
    - Same-cycle rename and writeback updates are discarded.
- Register 0 is never written: rename, writeback and retire targeting x0 are ignored.
- No backpressure. Every valid slot is accepted each cycle.
- Rename during the cycle of a flush: the outputs are still computed, but the upstream is responsible for discarding them.

Optional Feature:
- Macro RAT_WB_BYPASS_EN.
  - Defined: read rule 3 is active, so a same-cycle writeback is forwarded to readers.
  - Undefined: rule 3 is removed. A reader sees PEND/tag in the writeback cycle and gets the value from the next cycle onward.

Test Plan:
1. Reset, then read rs1=5, rs2=0 in slot 0 → valid=1/1, values 0/0.
2. Slot0 rd=3 robid=0x10, slot1 rs1=3 in the same cycle → slot1 rat_rs1_valid=0, tagval=0x10. Next cycle, reading x3 → PEND tag 0x10.
3. With x3 PEND tag 0x10:
   - wb_robid=0x10, result 0xDEADBEEF; reading x3 in the same cycle → valid=1, 0xDEADBEEF (bypass build), or valid=0/0x10 (no bypass). The next cycle reads 0xDEADBEEF in both builds.
   - A separate wb with robid 0x0F → no state change.
4. x3 renamed to 0x11 while a wb for 0x10 arrives → remains PEND 0x11. A later retire rd=3 robid=0x10 value 7 → comm[3]=7, entry stays PEND.
5. x4 SPEC 0x55 tag 0x20 with comm[4]=1, then rob_flush (plus a same-cycle rename of x4) → next cycle x4 reads valid=1, value 1.
6. Rename rd=0 and wb rd=0 result 9 → x0 still reads valid=1, value 0.
